serial_add_sub: RTL and testbench

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

---
 rtl/serial_add_sub.sv | 123 ++++++++++++
 tb/tb_serial_add_sub.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per cycle, LSB slice first,
// with a valid/ready handshake on both the operand and the result side.
module serial_add_sub #(
   parameter int WIDTH = 14,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic [WIDTH-1:0] first_num,
   input  logic [WIDTH-1:0] second_num,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("serial_add_sub: DIGIT must divide WIDTH and lie in 1..WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_cout;
   logic             r_ovf;

   logic [DIGIT-1:0] w_a_sl;
   logic [DIGIT-1:0] w_b_sl;
   logic [DIGIT-1:0] w_sum;
   logic             w_cout;
   logic             w_cmsb;
   logic             w_last;

   assign w_last = (r_cnt == CW'(N - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_next = BUSY;
         BUSY:    if (w_last)    w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Ripple full-add over the current slice; the carry into the slice MSB is
   // kept so the last slice can produce signed overflow.
   always_comb begin
      logic c;
      w_a_sl = r_a[int'(r_cnt) * DIGIT +: DIGIT];
      w_b_sl = r_b[int'(r_cnt) * DIGIT +: DIGIT];
      w_sum  = '0;
      w_cmsb = 1'b0;
      c      = r_carry;
      for (int i = 0; i < DIGIT; i++) begin
         w_sum[i] = w_a_sl[i] ^ w_b_sl[i] ^ c;
         if (i == DIGIT - 1) w_cmsb = c;
         c = (w_a_sl[i] & w_b_sl[i]) | (c & (w_a_sl[i] ^ w_b_sl[i]));
      end
      w_cout = c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction as a + ~b + 1: the carry register supplies the +1.
                  r_a     <= first_num;
                  r_b     <= sub ? ~second_num : second_num;
                  r_carry <= sub;
                  r_cnt   <= '0;
               end
            end
            BUSY: begin
               r_res[int'(r_cnt) * DIGIT +: DIGIT] <= w_sum;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_cout <= w_cout;
                  r_ovf  <= w_cmsb ^ w_cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign result    = r_res;
   assign carry_out = r_cout;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: three instances (DIGIT = 2, 1, 14) share
// operands; each has its own handshake so operations run one instance at a time.
module tb_serial_add_sub;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  in_valid;
   logic [2:0]  in_ready;
   logic [2:0]  out_valid;
   logic [2:0]  out_ready;
   logic        sub;
   logic [13:0] a;
   logic [13:0] b;
   logic [13:0] res [3];
   logic [2:0]  cout;
   logic [2:0]  ovf;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   serial_add_sub #(.WIDTH(14), .DIGIT(2)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .sub(sub),
      .first_num(a), .second_num(b), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .result(res[0]), .carry_out(cout[0]), .overflow(ovf[0]));

   serial_add_sub #(.WIDTH(14), .DIGIT(1)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .sub(sub),
      .first_num(a), .second_num(b), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .result(res[1]), .carry_out(cout[1]), .overflow(ovf[1]));

   serial_add_sub #(.WIDTH(14), .DIGIT(14)) u_d14 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .sub(sub),
      .first_num(a), .second_num(b), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .result(res[2]), .carry_out(cout[2]), .overflow(ovf[2]));

   // Drives one operation on instance k and takes the result; lat = -1 on timeout.
   task automatic run_op(input int k, input logic [13:0] x, input logic [13:0] y,
                         input logic s, output logic [13:0] r, output logic c,
                         output logic o, output int lat);
      int t;
      lat = -1;
      t   = 0;
      while (!in_ready[k] && t < 50) begin
         @(posedge clk); #1; t++;
      end
      a = x; b = y; sub = s;
      in_valid[k] = 1'b1;
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (out_valid[k]) begin
            lat = i;
            break;
         end
      end
      r = res[k]; c = cout[k]; o = ovf[k];
      out_ready[k] = 1'b1;
      @(posedge clk); #1;
      out_ready[k] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_total++;
         if (in_ready[k] !== 1'b1) $display("FAIL reset_in_ready d%0d: got %b want 1", k, in_ready[k]);
         else n_pass++;
         n_total++;
         if (out_valid[k] !== 1'b0) $display("FAIL reset_out_valid d%0d: got %b want 0", k, out_valid[k]);
         else n_pass++;
         n_total++;
         if (res[k] !== 14'h0) $display("FAIL reset_result d%0d: got %h want 0000", k, res[k]);
         else n_pass++;
         n_total++;
         if (cout[k] !== 1'b0) $display("FAIL reset_carry d%0d: got %b want 0", k, cout[k]);
         else n_pass++;
         n_total++;
         if (ovf[k] !== 1'b0) $display("FAIL reset_overflow d%0d: got %b want 0", k, ovf[k]);
         else n_pass++;
      end
   endtask

   // Shared vector runner for the add and subtract tables across all instances.
   task automatic test_vectors(input string name, input logic s,
                               input logic [13:0] ta [3], input logic [13:0] tb [3],
                               input logic [13:0] er [3], input logic ec [3],
                               input logic eo [3]);
      int          lt [3] = '{7, 14, 1};
      int          lat;
      logic [13:0] r;
      logic        c;
      logic        o;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 3; i++) begin
            run_op(k, ta[i], tb[i], s, r, c, o, lat);
            n_total++;
            if (r !== er[i]) $display("FAIL %s_result d%0d #%0d: got %h want %h", name, k, i, r, er[i]);
            else n_pass++;
            n_total++;
            if (c !== ec[i]) $display("FAIL %s_carry d%0d #%0d: got %b want %b", name, k, i, c, ec[i]);
            else n_pass++;
            n_total++;
            if (o !== eo[i]) $display("FAIL %s_overflow d%0d #%0d: got %b want %b", name, k, i, o, eo[i]);
            else n_pass++;
            n_total++;
            if (lat !== lt[k]) $display("FAIL %s_latency d%0d #%0d: got %0d want %0d", name, k, i, lat, lt[k]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_add();
      logic [13:0] ta [3] = '{14'd100, 14'h3FFF, 14'h1FFF};
      logic [13:0] tb [3] = '{14'd250, 14'h0001, 14'h0001};
      logic [13:0] er [3] = '{14'h015E, 14'h0000, 14'h2000};
      logic        ec [3] = '{1'b0, 1'b1, 1'b0};
      logic        eo [3] = '{1'b0, 1'b0, 1'b1};
      test_vectors("add", 1'b0, ta, tb, er, ec, eo);
   endtask

   task automatic test_sub();
      logic [13:0] ta [3] = '{14'd7, 14'd5, 14'h2000};
      logic [13:0] tb [3] = '{14'd5, 14'd7, 14'h0001};
      logic [13:0] er [3] = '{14'h0002, 14'h3FFE, 14'h1FFF};
      logic        ec [3] = '{1'b1, 1'b0, 1'b1};
      logic        eo [3] = '{1'b0, 1'b0, 1'b1};
      test_vectors("sub", 1'b1, ta, tb, er, ec, eo);
   endtask

   task automatic test_backpressure();
      int          lat;
      logic [13:0] r;
      logic        c;
      logic        o;
      bit          seen = 1'b0;
      a = 14'h0123; b = 14'h0456; sub = 1'b0;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         seen = out_valid[0];
      end
      n_total++;
      if (!seen) $display("FAIL bp_done_timeout: got out_valid 0 want 1");
      else n_pass++;
      a = 14'h1111; b = 14'h2222; sub = 1'b1;
      in_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_total++;
         if (res[0] !== 14'h0579 || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1)
            $display("FAIL bp_hold cyc%0d: got res %h rdy %b vld %b want res 0579 rdy 0 vld 1",
                     i, res[0], in_ready[0], out_valid[0]);
         else n_pass++;
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      n_total++;
      if (out_valid[0] !== 1'b0) $display("FAIL bp_take_valid: got %b want 0", out_valid[0]);
      else n_pass++;
      n_total++;
      if (in_ready[0] !== 1'b1) $display("FAIL bp_take_ready: got %b want 1", in_ready[0]);
      else n_pass++;
      run_op(0, 14'h0010, 14'h0020, 1'b0, r, c, o, lat);
      n_total++;
      if (r !== 14'h0030 || lat !== 7) $display("FAIL bp_next_op: got %h lat %0d want 0030 lat 7", r, lat);
      else n_pass++;
   endtask

   task automatic test_reset_abort();
      int          lat;
      logic [13:0] r;
      logic        c;
      logic        o;
      logic        vseen = 1'b0;
      a = 14'h1234; b = 14'h0101; sub = 1'b0;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         vseen |= out_valid[0];
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vseen |= out_valid[0];
      n_total++;
      if (vseen !== 1'b0) $display("FAIL abort_valid_seen: got %b want 0", vseen);
      else n_pass++;
      n_total++;
      if (in_ready[0] !== 1'b1) $display("FAIL abort_in_ready: got %b want 1", in_ready[0]);
      else n_pass++;
      n_total++;
      if (res[0] !== 14'h0) $display("FAIL abort_result: got %h want 0000", res[0]);
      else n_pass++;
      n_total++;
      if (cout[0] !== 1'b0 || ovf[0] !== 1'b0)
         $display("FAIL abort_flags: got c %b o %b want 0 0", cout[0], ovf[0]);
      else n_pass++;
      // No out_valid must surface afterwards either.
      repeat (10) begin
         @(posedge clk); #1;
         vseen |= out_valid[0];
      end
      n_total++;
      if (vseen !== 1'b0) $display("FAIL abort_late_valid: got %b want 0", vseen);
      else n_pass++;
      run_op(0, 14'd1, 14'd1, 1'b0, r, c, o, lat);
      n_total++;
      if (r !== 14'd2 || c !== 1'b0 || o !== 1'b0 || lat !== 7)
         $display("FAIL abort_next_op: got %h c %b o %b lat %0d want 0002 0 0 lat 7", r, c, o, lat);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1; in_valid = '0; out_ready = '0; sub = 1'b0; a = '0; b = '0;
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
